// File: rtl/mdu_sequencer.sv
// Sequential unsigned multiply/divide unit: one shift-add or restoring shift-subtract
// step per clock over a 2N-bit working register, with stall, flush and done signalling.
module mdu_sequencer #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         flush,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [1:0]     op_r, op_s;
  logic [N-1:0]   opnd_r, opnd_s;   // multiplicand for MUL*, divisor for DIV*/REM*
  logic [2*N-1:0] work_r, work_s;
  logic [N-1:0]   result_r, result_s;
  logic [N:0]     mul_sum_s;
  logic [2*N:0]   div_shift_s;
  logic [N:0]     div_upper_s;
  logic [N-1:0]   div_diff_s;
  logic           done_s;

  // Low half holds the product low word / quotient, high half the product high word / remainder.
  function automatic logic [N-1:0] select_result(input logic [1:0] sel_op,
                                                 input logic [2*N-1:0] w);
    logic [N-1:0] r;
    case (sel_op)
      2'b00:   r = w[N-1:0];
      2'b01:   r = w[2*N-1:N];
      2'b10:   r = w[N-1:0];
      2'b11:   r = w[2*N-1:N];
      default: r = {N{1'b0}};
    endcase
    return r;
  endfunction

  // One iteration of either algorithm; the divide shift keeps an extra top bit so 2*rem+1 never overflows.
  always_comb begin
    mul_sum_s   = {1'b0, work_r[2*N-1:N]} + (work_r[0] ? {1'b0, opnd_r} : {(N+1){1'b0}});
    div_shift_s = {work_r, 1'b0};
    div_upper_s = div_shift_s[2*N:N];
    div_diff_s  = div_upper_s[N-1:0] - opnd_r;
  end

  // Next-state and datapath update.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    op_s     = op_r;
    opnd_s   = opnd_r;
    work_s   = work_r;
    result_s = result_r;
    case (state_r)
      IDLE: begin
        if (start && !flush) begin
          op_s  = op;
          cnt_s = {CW{1'b0}};
          if (op[1] && (b == {N{1'b0}})) begin
            // Divide by zero: place the fixed answers where select_result will find them.
            state_s = DONE;
            opnd_s  = b;
            work_s  = {a, {N{1'b1}}};
          end else begin
            state_s = RUN;
            opnd_s  = op[1] ? b : a;
            work_s  = {{N{1'b0}}, (op[1] ? a : b)};
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
          if (op_r[1]) begin
            if (div_upper_s >= {1'b0, opnd_r}) begin
              work_s = {div_diff_s, div_shift_s[N-1:1], 1'b1};
            end else begin
              work_s = div_shift_s[2*N-1:0];
            end
          end else begin
            work_s = {mul_sum_s, work_r[N-1:1]};
          end
          if (cnt_r == CW'(N-1)) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end
      end
      DONE: begin
        state_s = IDLE;
        if (!flush) begin
          result_s = select_result(op_r, work_r);
        end else begin
          result_s = result_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      op_r     <= 2'b00;
      opnd_r   <= {N{1'b0}};
      work_r   <= {(2*N){1'b0}};
      result_r <= {N{1'b0}};
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      op_r     <= op_s;
      opnd_r   <= opnd_s;
      work_r   <= work_s;
      result_r <= result_s;
    end
  end

  // A flush in DONE suppresses both the pulse and the new result in the same cycle.
  always_comb begin
    ready  = (state_r == IDLE);
    busy   = (state_r != IDLE);
    done_s = (state_r == DONE) && !flush;
    done   = done_s;
    if (done_s) begin
      result = select_result(op_r, work_r);
    end else begin
      result = result_r;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: latency, MUL/MULHU/DIVU/REMU values,
// divide by zero, flush, async reset and ignored start.
module tb_mdu_sequencer;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         flush;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  int checks = 0;
  int errors = 0;

  mdu_sequencer #(.N(N), .CW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Called at posedge+1 in IDLE; returns in the done cycle (or at the timeout).
  task automatic run_op(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                        output int lat, output logic [N-1:0] res);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_timing();
    int lat;
    logic saw_done;
    saw_done = 1'b0;
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    checks++; if (ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mul_cycle1 got ready=%b busy=%b want 0/1", ready, busy); end
    lat = 1;
    while (lat < 33) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL mul_early_done got 1 want 0"); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mul_done_c33 got %b want 1", done); end
    checks++; if (result !== 32'h0000_002A) begin errors++; $display("FAIL mul_7x6 got %h want 0000002a", result); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL mul_c34 got ready=%b done=%b want 1/0", ready, done); end
  endtask

  task automatic test_mul_wide();
    int lat;
    logic [N-1:0] res;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
    checks++; if (res !== 32'hFFFF_FFFE || lat != 33) begin errors++; $display("FAIL mulhu_max got %h lat %0d want fffffffe lat 33", res, lat); end
    @(posedge clk); #1;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
    checks++; if (res !== 32'h0000_0001) begin errors++; $display("FAIL mul_max got %h want 00000001", res); end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    int lat;
    logic [N-1:0] res;
    run_op(2'b10, 32'd100, 32'd7, lat, res);
    checks++; if (res !== 32'd14 || lat != 33) begin errors++; $display("FAIL divu_100_7 got %0d lat %0d want 14 lat 33", res, lat); end
    @(posedge clk); #1;
    run_op(2'b11, 32'd100, 32'd7, lat, res);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %0d want 2", res); end
    @(posedge clk); #1;
    run_op(2'b10, 32'd5, 32'd9, lat, res);
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL divu_5_9 got %0d want 0", res); end
    @(posedge clk); #1;
    run_op(2'b11, 32'd5, 32'd9, lat, res);
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL remu_5_9 got %0d want 5", res); end
    @(posedge clk); #1;
    run_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, lat, res);
    checks++; if (res !== 32'd1) begin errors++; $display("FAIL divu_big got %h want 00000001", res); end
    @(posedge clk); #1;
    run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, lat, res);
    checks++; if (res !== 32'h7FFF_FFFE) begin errors++; $display("FAIL remu_big got %h want 7ffffffe", res); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat;
    logic [N-1:0] res;
    run_op(2'b10, 32'h0000_1234, 32'h0, lat, res);
    checks++; if (res !== 32'hFFFF_FFFF || lat != 1) begin errors++; $display("FAIL divu_zero got %h lat %0d want ffffffff lat 1", res, lat); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL divu_zero_after got ready=%b busy=%b want 1/0", ready, busy); end
    run_op(2'b11, 32'h0000_1234, 32'h0, lat, res);
    checks++; if (res !== 32'h0000_1234 || lat != 1) begin errors++; $display("FAIL remu_zero got %h lat %0d want 00001234 lat 1", res, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int lat;
    logic [N-1:0] res;
    logic saw_done;
    saw_done = 1'b0;
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL flush_cycle got done=%b busy=%b want 0/1", done, busy); end
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_idle got ready=%b busy=%b want 1/0", ready, busy); end
    checks++; if (result !== 32'h0000_1234) begin errors++; $display("FAIL flush_result got %h want 00001234", result); end
    for (int i = 0; i < 35; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL flush_no_done got 1 want 0"); end
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_idle_start got ready=%b want 1", ready); end
    run_op(2'b10, 32'd1000, 32'd3, lat, res);
    checks++; if (res !== 32'd333 || lat != 33) begin errors++; $display("FAIL after_flush_divu got %0d lat %0d want 333 lat 33", res, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #4;
    reset = 1'b1;
    #1;
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_rst_ctrl got r=%b b=%b d=%b want 1/0/0", ready, busy, done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL async_rst_result got %h want 0", result); end
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL async_rst_after got ready=%b done=%b want 1/0", ready, done); end
  endtask

  task automatic test_start_held();
    int lat;
    logic saw_busy;
    saw_busy = 1'b0;
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    op = 2'b10; a = 32'd77; b = 32'd0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (result !== 32'd15 || lat != 33) begin errors++; $display("FAIL held_mul got %0d lat %0d want 15 lat 33", result, lat); end
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b0 || result !== 32'd15) begin errors++; $display("FAIL held_no_second got busy=%b result=%0d want 0/15", saw_busy, result); end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_mul_wide();
    test_div();
    test_div_zero();
    test_flush();
    test_async_reset();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle unsigned multiply/divide unit for the pipelined core's execute stage.
- Iterates one shift-add or shift-subtract step per clock over an internal 2N-bit working register.
- Drives busy to the hazard unit so the pipeline stalls until the result is ready.
- The pipeline can abort an in-flight operation with flush on a branch mispredict.

Parameters:
- N, 32, operand and result width in bits.
- CW, 6, iteration counter width; must satisfy 2^CW > N.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- op  input  2  operation: 00 MUL (low N bits), 01 MULHU (high N bits), 10 DIVU (quotient), 11 REMU (remainder).
- a  input  N  multiplicand or dividend.
- b  input  N  multiplier or divisor.
- flush  input  1  abort the in-flight operation.
- ready  output  1  high in IDLE; start is accepted only while ready=1.
- busy  output  1  high in RUN and DONE; used as the stall request.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  N  operation result.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, counter=0, working registers=0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: on a clock edge with start=1 (and flush=0).
  - a, b and op are latched.
  - counter is cleared to 0.
  - Inputs are don't-care after the acceptance edge.
- IDLE -> DONE: on a clock edge with start=1 and op[1]=1 and b=0 (divide by zero).
  - Result is fixed at the acceptance edge: DIVU gives all ones, REMU gives a.
  - No RUN cycles.
- RUN: exactly N iterations, one per clock, counter 0..N-1.
  - On the edge where counter=N-1, go to DONE.
- RUN iteration, multiply: working register P is 2N bits, initialised {0, b}.
  - If P[0]=1, add a to P[2N-1:N] with an (N+1)-bit sum.
  - Then shift {carry, P} right by 1.
- RUN iteration, divide: restoring division. Working register R is 2N bits, initialised {0, a}.
  - Shift R left by 1.
  - If R[2N-1:N] >= b, subtract b from the upper half and set R[0]=1.
- DONE: done=1 for exactly one cycle. Next edge goes to IDLE unconditionally.
- Result selection in DONE (registered; result holds its value until the next done):
  - MUL: P[N-1:0].
  - MULHU: P[2N-1:N].
  - DIVU: R[N-1:0].
  - REMU: R[2N-1:N].
- Latency: with start accepted at edge k, done is high in the cycle after edge k+N, i.e. N+1 cycles after acceptance. Divide by zero: done is high in the cycle after edge k.
- Throughput: one operation per N+2 cycles. start during RUN or DONE is ignored and not queued.
- flush in RUN or DONE: next edge goes to IDLE.
  - done is not asserted (a DONE-state done is suppressed combinationally while flush=1).
  - result is not updated.
- flush in IDLE: no effect. start is not accepted in the same cycle.
- Reset mid-operation: immediate return to reset values, with no done.
- All arithmetic is unsigned, modulo 2^N on outputs. No overflow flags.

Test Plan:
- MUL, a=7, b=6, start at cycle 0 -> ready=0 and busy=1 from cycle 1; done=1 only in cycle 33 with result=0x0000002A; ready=1 in cycle 34.
- MULHU, a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE; same operands with MUL -> 0x00000001.
- DIVU, a=100, b=7 -> 14; REMU with the same operands -> 2. Also a=5, b=9: DIVU -> 0, REMU -> 5.
- Divide by zero, a=0x1234, b=0:
  - DIVU -> done in cycle 1 with result 0xFFFFFFFF.
  - REMU -> done in cycle 1 with result 0x00001234.
  - No RUN cycles observed.
- Flush at counter=10 during DIVU:
  - IDLE on the next edge, no done pulse, result keeps its previous value.
  - A new start accepted immediately completes correctly.
- Async reset asserted mid-RUN (between clock edges):
  - ready=1, busy=0, done=0, result=0 immediately.
  - start held high during RUN is ignored, and no second operation follows done.
